// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional op statistics counters are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned MODE_W = 4,
  parameter int unsigned PSW_W  = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [MODE_W-1:0] req0_mode,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [MODE_W-1:0] req1_mode,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_s,
  output logic [DATA_W-1:0] rsp_s2,
  output logic [PSW_W-1:0]  rsp_psw,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [MODE_W-1:0] alu_mode,
  input  logic [DATA_W-1:0] alu_s,
  input  logic [DATA_W-1:0] alu_s2,
  input  logic [PSW_W-1:0]  alu_psw,
  output logic [CNT_W-1:0]  stat_cnt0,
  output logic [CNT_W-1:0]  stat_cnt1
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q, state_d;
  logic              owner_q, last_grant_q;
  logic [DATA_W-1:0] a_q, b_q, s_q, s2_q;
  logic [MODE_W-1:0] mode_q;
  logic [PSW_W-1:0]  psw_q;
  logic              grant;
  logic              accept;
  logic              rsp_hs;

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    accept     = 1'b0;
    rsp_hs     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    // On a tie the port that did not win last time is granted.
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = req1_valid;
    end
    unique case (state_q)
      StIdle: begin
        // Gated by rst so no ready escapes while reset is held.
        accept     = (req0_valid | req1_valid) & ~rst;
        req0_ready = accept & ~grant;
        req1_ready = accept & grant;
        if (accept) state_d = StExec;
      end
      StExec: begin
        state_d = StResp;
      end
      StResp: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
        rsp_hs     = owner_q ? rsp1_ready : rsp0_ready;
        if (rsp_hs) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      mode_q       <= '0;
      s_q          <= '0;
      s2_q         <= '0;
      psw_q        <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q          <= grant ? req1_a : req0_a;
        b_q          <= grant ? req1_b : req0_b;
        mode_q       <= grant ? req1_mode : req0_mode;
        owner_q      <= grant;
        last_grant_q <= grant;
      end
      if (state_q == StExec) begin
        s_q   <= alu_s;
        s2_q  <= alu_s2;
        psw_q <= alu_psw;
      end
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_mode = mode_q;
  assign rsp_s    = s_q;
  assign rsp_s2   = s2_q;
  assign rsp_psw  = psw_q;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  // Saturating completion counters, one per response channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (rsp_hs) begin
      if (!owner_q && (cnt0_q != {CNT_W{1'b1}})) cnt0_q <= cnt0_q + 1'b1;
      if (owner_q && (cnt1_q != {CNT_W{1'b1}}))  cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign stat_cnt0 = cnt0_q;
  assign stat_cnt1 = cnt1_q;
`else
  assign stat_cnt0 = '0;
  assign stat_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: reference ALU model, per-scenario tasks.
module tb_alu_arbiter;
  localparam logic [3:0] MODE_ADD = 4'd0;
  localparam logic [3:0] MODE_SUB = 4'd1;
  localparam logic [3:0] MODE_AND = 4'd2;
  localparam logic [3:0] MODE_XOR = 4'd3;
`ifdef ALU_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {logic [63:0] s; logic [63:0] s2; logic [15:0] psw;} res_t;
  typedef struct {logic p; res_t r; int acc;} exp_t;

  function automatic res_t alu_ref(input logic [63:0] a, input logic [63:0] b,
                                   input logic [3:0] m);
    res_t r;
    case (m)
      MODE_ADD: r.s = a + b;
      MODE_SUB: r.s = a - b;
      MODE_AND: r.s = a & b;
      default:  r.s = a ^ b;
    endcase
    r.s2  = a ^ {b[31:0], b[63:32]};
    r.psw = {m, 11'd0, (r.s == 64'd0)};
    return r;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0] req0_mode = '0, req1_mode = '0;
  logic [63:0] rsp_s, rsp_s2, alu_a, alu_b, alu_s, alu_s2;
  logic [15:0] rsp_psw, alu_psw, stat_cnt0, stat_cnt1;
  logic [3:0] alu_mode;

  always #5 clk = ~clk;

  assign {alu_s, alu_s2, alu_psw} = alu_ref(alu_a, alu_b, alu_mode);

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_mode(req1_mode),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_s(rsp_s), .rsp_s2(rsp_s2), .rsp_psw(rsp_psw),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
    .alu_s(alu_s), .alu_s2(alu_s2), .alu_psw(alu_psw),
    .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
  );

  // Second copy with 2-bit counters sees identical stimulus to check saturation.
  logic sat_r0, sat_r1, sat_v0, sat_v1;
  logic [63:0] sat_s, sat_s2, sat_a, sat_b, sat_as, sat_as2;
  logic [15:0] sat_psw, sat_apsw;
  logic [3:0] sat_mode;
  logic [1:0] sat_cnt0, sat_cnt1;

  assign {sat_as, sat_as2, sat_apsw} = alu_ref(sat_a, sat_b, sat_mode);

  alu_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(sat_r0), .req0_a(req0_a), .req0_b(req0_b),
    .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(sat_r1), .req1_a(req1_a), .req1_b(req1_b),
    .req1_mode(req1_mode),
    .rsp0_valid(sat_v0), .rsp0_ready(rsp0_ready),
    .rsp1_valid(sat_v1), .rsp1_ready(rsp1_ready),
    .rsp_s(sat_s), .rsp_s2(sat_s2), .rsp_psw(sat_psw),
    .alu_a(sat_a), .alu_b(sat_b), .alu_mode(sat_mode),
    .alu_s(sat_as), .alu_s2(sat_as2), .alu_psw(sat_apsw),
    .stat_cnt0(sat_cnt0), .stat_cnt1(sat_cnt1)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  exp_t sb[$];
  int grants[$];
  int done[2];
  logic [63:0] last_s[2];
  logic pv[2];
  res_t held, cur;
  exp_t ex;
  logic mv, mr;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: push expectations on accept, compare on response.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      pv[0] = 1'b0;
      pv[1] = 1'b0;
    end else begin
      if (req0_ready || req1_ready) begin
        total++;
        if (req0_ready && req1_ready) begin
          bad++;
          $display("FAIL ready_onehot got r0=%b r1=%b want at most one", req0_ready, req1_ready);
        end
      end
      if (req0_valid && req0_ready) begin
        sb.push_back('{1'b0, alu_ref(req0_a, req0_b, req0_mode), cyc});
        grants.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        sb.push_back('{1'b1, alu_ref(req1_a, req1_b, req1_mode), cyc});
        grants.push_back(1);
      end
      for (int p = 0; p < 2; p++) begin
        mv  = (p == 0) ? rsp0_valid : rsp1_valid;
        mr  = (p == 0) ? rsp0_ready : rsp1_ready;
        cur = {rsp_s, rsp_s2, rsp_psw};
        if (mv) begin
          total++;
          if (!pv[p]) begin
            if (sb.size() == 0) begin
              bad++;
              $display("FAIL rsp%0d_unexpected got valid=1 want no response", p);
            end else begin
              ex = sb[0];
              if (ex.p !== p[0] || cur !== ex.r || (cyc - ex.acc) != 2) begin
                bad++;
                $display("FAIL rsp%0d_result got port=%0d res=%h lat=%0d want port=%0d res=%h lat=2",
                         p, p, cur, cyc - ex.acc, ex.p, ex.r);
              end
            end
            held = cur;
          end else if (cur !== held) begin
            bad++;
            $display("FAIL rsp%0d_stable got %h want %h", p, cur, held);
          end
          if (mr) begin
            if (sb.size() != 0) void'(sb.pop_front());
            done[p]++;
            last_s[p] = rsp_s;
          end
        end
        pv[p] = mv && !mr;
      end
    end
  end

  task automatic issue(input int p, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] m);
    bit got = 1'b0;
    if (p == 0) begin
      req0_a = a; req0_b = b; req0_mode = m; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_mode = m; req1_valid = 1'b1;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    if (p == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
    if (!got) begin
      total++; bad++;
      $display("FAIL issue_timeout port=%0d got ready=0 want ready=1", p);
    end
  endtask

  task automatic wait_done;
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp0_valid && !rsp1_valid && !req0_valid && !req1_valid) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    if (!ok) begin
      total++; bad++;
      $display("FAIL drain_timeout got pending=%0d want 0", sb.size());
    end
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    total++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0) begin
      bad++;
      $display("FAIL %s_handshake got %b want 0000", tag,
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
    end
    total++;
    if ({alu_a, alu_b, alu_mode, rsp_s, rsp_s2, rsp_psw, stat_cnt0, stat_cnt1} !== '0) begin
      bad++;
      $display("FAIL %s_data got a=%h b=%h m=%h s=%h s2=%h psw=%h c0=%h c1=%h want all 0", tag,
               alu_a, alu_b, alu_mode, rsp_s, rsp_s2, rsp_psw, stat_cnt0, stat_cnt1);
    end
  endtask

  task automatic test_reset;
    req0_a = 64'h11; req1_a = 64'h22; req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check_zero("reset");
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single;
    int d1 = done[1];
    issue(0, 64'h20, 64'h30, MODE_ADD);
    wait_done();
    total++;
    if (last_s[0] !== 64'h50 || done[0] != 1 || done[1] != d1) begin
      bad++;
      $display("FAIL single got s=%h d0=%0d d1=%0d want s=50 d0=1 d1=%0d",
               last_s[0], done[0], done[1], d1);
    end
  endtask

  task automatic test_tie;
    pulse_reset();
    grants.delete();
    fork
      issue(0, 64'h50, 64'h40, MODE_SUB);
      issue(1, 64'h1, 64'h2, MODE_ADD);
    join
    wait_done();
    total++;
    if (grants.size() != 2 || grants[0] != 0 || grants[1] != 1 ||
        last_s[0] !== 64'h10 || last_s[1] !== 64'h3) begin
      bad++;
      $display("FAIL tie got n=%0d s0=%h s1=%h want order 0,1 s0=10 s1=3",
               grants.size(), last_s[0], last_s[1]);
    end
  endtask

  task automatic test_back_to_back;
    grants.delete();
    fork
      begin
        issue(0, 64'h100, 64'h1, MODE_ADD);
        issue(0, 64'h200, 64'h2, MODE_SUB);
      end
      begin
        issue(1, 64'h300, 64'h3, MODE_XOR);
        issue(1, 64'h400, 64'h4, MODE_AND);
      end
    join
    wait_done();
    total++;
    if (grants.size() != 4 || grants[0] != 0 || grants[1] != 1 || grants[2] != 0 ||
        grants[3] != 1) begin
      bad++;
      $display("FAIL rr_order got n=%0d g=%p want 0,1,0,1", grants.size(), grants);
    end
  endtask

  task automatic test_modes;
    int d0 = done[0];
    int d1 = done[1];
    issue(1, 64'hffff_ffff_ffff_ffff, 64'h1, MODE_ADD);
    issue(0, 64'h0, 64'h1, MODE_SUB);
    issue(1, 64'hf0f0, 64'hff00, MODE_AND);
    issue(0, 64'h1234, 64'h1234, MODE_XOR);
    wait_done();
    total++;
    if (done[0] != d0 + 2 || done[1] != d1 + 2 || last_s[0] !== 64'h0) begin
      bad++;
      $display("FAIL modes got d0=%0d d1=%0d s0=%h want d0=%0d d1=%0d s0=0",
               done[0], done[1], last_s[0], d0 + 2, d1 + 2);
    end
  endtask

  task automatic test_hold;
    grants.delete();
    rsp0_ready = 1'b0;
    fork
      begin
        issue(0, 64'h77, 64'h11, MODE_SUB);
        for (int i = 0; i < 10 && !rsp0_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          total++;
          if (rsp0_valid !== 1'b1 || req1_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold got v0=%b r1=%b want v0=1 r1=0", rsp0_valid, req1_ready);
          end
        end
        @(posedge clk); #1;
        rsp0_ready = 1'b1;
      end
      begin
        @(posedge clk); #1;
        issue(1, 64'h5, 64'h6, MODE_ADD);
      end
    join
    wait_done();
    total++;
    if (grants.size() != 2 || grants[0] != 0 || grants[1] != 1 || last_s[0] !== 64'h66) begin
      bad++;
      $display("FAIL hold_order got n=%0d s0=%h want order 0,1 s0=66", grants.size(), last_s[0]);
    end
  endtask

  task automatic test_reset_mid;
    int d1 = done[1];
    issue(1, 64'h7, 64'h8, MODE_ADD);
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    total++;
    if (done[1] != d1 || rsp1_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_discard got d1=%0d v1=%b want d1=%0d v1=0", done[1], rsp1_valid, d1);
    end
    @(posedge clk); #1;
    grants.delete();
    fork
      issue(0, 64'h9, 64'h1, MODE_ADD);
      issue(1, 64'h9, 64'h2, MODE_ADD);
    join
    wait_done();
    total++;
    if (grants.size() != 2 || grants[0] != 0) begin
      bad++;
      $display("FAIL rst_tie got n=%0d first=%0d want first=0", grants.size(),
               grants.size() != 0 ? grants[0] : -1);
    end
  endtask

  task automatic test_stats;
    pulse_reset();
    for (int i = 0; i < 3; i++) issue(0, 64'(i), 64'h1, MODE_ADD);
    issue(1, 64'h2, 64'h2, MODE_SUB);
    wait_done();
    total++;
    if (stat_cnt0 !== (STATS ? 16'd3 : 16'd0) || stat_cnt1 !== (STATS ? 16'd1 : 16'd0)) begin
      bad++;
      $display("FAIL stats got c0=%0d c1=%0d want c0=%0d c1=%0d", stat_cnt0, stat_cnt1,
               STATS ? 3 : 0, STATS ? 1 : 0);
    end
    for (int i = 0; i < 2; i++) issue(0, 64'h40, 64'(i), MODE_XOR);
    wait_done();
    total++;
    if (stat_cnt0 !== (STATS ? 16'd5 : 16'd0) || sat_cnt0 !== (STATS ? 2'd3 : 2'd0)) begin
      bad++;
      $display("FAIL stats_sat got c0=%0d sat0=%0d want c0=%0d sat0=%0d", stat_cnt0, sat_cnt0,
               STATS ? 5 : 0, STATS ? 3 : 0);
    end
  endtask

  initial begin
    done[0] = 0;
    done[1] = 0;
    last_s[0] = '0;
    last_s[1] = '0;
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_modes();
    test_hold();
    test_reset_mid();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
